// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transmit sequencer.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CA       = 3'd2,
        ST_LATENCY  = 3'd3,
        ST_DATA     = 3'd4,
        ST_CS_HOLD  = 3'd5
    } state_e;

    localparam int CA_W      = 48;
    localparam int CA_RD_BIT = 47;
    localparam int CA_AS_BIT = 46;
    localparam int BURST_W   = 9;
    localparam int LAT_W     = 4;
    localparam int LATC_W    = LAT_W + 1;
    localparam int CNT_W     = 10;

    // CA word k: rise byte in [15:8], fall byte in [7:0]
    function automatic logic [15:0] ca_word(input logic [CA_W-1:0] ca,
                                            input logic [1:0] k);
        logic [CA_W-1:0] s;
        s = ca << {k, 4'b0000};
        return s[47:32];
    endfunction

endpackage

// File: rtl/hyperbus_tx_seq.sv
// HyperBus command/latency/data sequencer, all outputs registered.
// Define HYPERBUS_FIXED_LATENCY_EN to force 2L latency and ignore rwds_i.
module hyperbus_tx_seq
    import hyperbus_pkg::*;
#(
    parameter int unsigned CS_HOLD = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trans_valid_i,
    output logic        trans_ready_o,
    input  logic [47:0] trans_ca_i,
    input  logic [8:0]  trans_burst_i,
    input  logic [3:0]  cfg_latency_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  logic [15:0] tx_data_i,
    input  logic [1:0]  tx_strb_i,
    input  logic        rwds_i,
    output logic        cs_no,
    output logic        ck_en_o,
    output logic [7:0]  dq_rise_o,
    output logic [7:0]  dq_fall_o,
    output logic        dq_oe_o,
    output logic        rwds_oe_o,
    output logic        rwds_rise_o,
    output logic        rwds_fall_o,
    output logic        busy_o
);

    localparam logic [2:0] HOLD_LAST = 3'(CS_HOLD - 1);

    state_e               state_q, state_d;
    logic [1:0]           ca_cnt_q, ca_cnt_d;
    logic [LATC_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           hold_cnt_q, hold_cnt_d;
    logic [CA_W-1:0]      ca_q, ca_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 dbl_q, dbl_d;

    logic                 trans_ready_q, trans_ready_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 cs_n_q, cs_n_d;
    logic                 ck_en_q, ck_en_d;
    logic [7:0]           dq_rise_q, dq_rise_d;
    logic [7:0]           dq_fall_q, dq_fall_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 rwds_oe_q, rwds_oe_d;
    logic                 rwds_rise_q, rwds_rise_d;
    logic                 rwds_fall_q, rwds_fall_d;
    logic                 busy_q, busy_d;

    logic                 hs_t, hs_w;
    logic                 is_rd, is_reg, skip_lat, pre_data;
    logic [CNT_W-1:0]     total;
    logic [LATC_W-1:0]    lat_len;
    logic [15:0]          ca_w;

    assign hs_t     = trans_valid_i & trans_ready_q;
    assign hs_w     = tx_valid_i & tx_ready_q;
    assign is_rd    = ca_q[CA_RD_BIT];
    assign is_reg   = ca_q[CA_AS_BIT];
    assign skip_lat = (!is_rd && is_reg) || (lat_q == '0);
    assign total    = {1'b0, burst_q} + 10'd1;
    assign lat_len  = dbl_q ? {lat_q, 1'b0} : {1'b0, lat_q};

    always_comb begin
        state_d    = state_q;
        ca_cnt_d   = ca_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, hs_w};
        hold_cnt_d = hold_cnt_q;
        ca_d       = ca_q;
        burst_d    = burst_q;
        lat_d      = lat_q;
        dbl_d      = dbl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs_t) begin
                    state_d = ST_CS_SETUP;
                    ca_d    = trans_ca_i;
                    burst_d = trans_burst_i;
                    lat_d   = cfg_latency_i;
                end
            end
            ST_CS_SETUP: begin
                state_d  = ST_CA;
                ca_cnt_d = 2'd0;
                cnt_d    = '0;
            end
            ST_CA: begin
                ca_cnt_d = ca_cnt_q + 2'd1;
                if (ca_cnt_q == 2'd0) begin
`ifdef HYPERBUS_FIXED_LATENCY_EN
                    dbl_d = 1'b1;
`else
                    dbl_d = rwds_i;
`endif
                end
                if (ca_cnt_q == 2'd2) begin
                    state_d   = skip_lat ? ST_DATA : ST_LATENCY;
                    lat_cnt_d = lat_len;
                end
            end
            ST_LATENCY: begin
                lat_cnt_d = lat_cnt_q - 5'd1;
                if (lat_cnt_q == 5'd1) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (is_rd) begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q + 10'd1 == total) state_d = ST_CS_HOLD;
                end else if (cnt_q == total) begin
                    state_d = ST_CS_HOLD;
                end
                hold_cnt_d = 3'd0;
            end
            ST_CS_HOLD: begin
                hold_cnt_d = hold_cnt_q + 3'd1;
                if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write words are fetched one cycle ahead so each DATA cycle can drive one.
    assign pre_data = (state_d == ST_CA && ca_cnt_d == 2'd2 && skip_lat) ||
                      (state_d == ST_LATENCY && lat_cnt_d == 5'd1);

    always_comb begin
        trans_ready_d = 1'b0;
        cs_n_d        = 1'b0;
        ck_en_d       = 1'b0;
        dq_oe_d       = 1'b0;
        rwds_oe_d     = 1'b0;
        dq_rise_d     = 8'h00;
        dq_fall_d     = 8'h00;
        rwds_rise_d   = 1'b0;
        rwds_fall_d   = 1'b0;
        busy_d        = 1'b1;
        ca_w          = ca_word(ca_q, ca_cnt_d);
        unique case (state_d)
            ST_IDLE: begin
                trans_ready_d = 1'b1;
                cs_n_d        = 1'b1;
                busy_d        = 1'b0;
            end
            ST_CA: begin
                ck_en_d   = 1'b1;
                dq_oe_d   = 1'b1;
                dq_rise_d = ca_w[15:8];
                dq_fall_d = ca_w[7:0];
            end
            ST_LATENCY: ck_en_d = 1'b1;
            ST_DATA: begin
                if (is_rd) begin
                    ck_en_d = 1'b1;
                end else begin
                    ck_en_d     = hs_w;
                    dq_oe_d     = 1'b1;
                    rwds_oe_d   = !is_reg;
                    dq_rise_d   = hs_w ? tx_data_i[15:8] : dq_rise_q;
                    dq_fall_d   = hs_w ? tx_data_i[7:0]  : dq_fall_q;
                    rwds_rise_d = hs_w ? ~tx_strb_i[1]   : rwds_rise_q;
                    rwds_fall_d = hs_w ? ~tx_strb_i[0]   : rwds_fall_q;
                end
            end
            default: ;
        endcase
        tx_ready_d = !is_rd && (cnt_d < total) &&
                     (pre_data || state_d == ST_DATA);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            ca_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            cnt_q         <= '0;
            hold_cnt_q    <= '0;
            ca_q          <= '0;
            burst_q       <= '0;
            lat_q         <= '0;
            dbl_q         <= 1'b0;
            trans_ready_q <= 1'b1;
            tx_ready_q    <= 1'b0;
            cs_n_q        <= 1'b1;
            ck_en_q       <= 1'b0;
            dq_rise_q     <= '0;
            dq_fall_q     <= '0;
            dq_oe_q       <= 1'b0;
            rwds_oe_q     <= 1'b0;
            rwds_rise_q   <= 1'b0;
            rwds_fall_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ca_cnt_q      <= ca_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            cnt_q         <= cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            ca_q          <= ca_d;
            burst_q       <= burst_d;
            lat_q         <= lat_d;
            dbl_q         <= dbl_d;
            trans_ready_q <= trans_ready_d;
            tx_ready_q    <= tx_ready_d;
            cs_n_q        <= cs_n_d;
            ck_en_q       <= ck_en_d;
            dq_rise_q     <= dq_rise_d;
            dq_fall_q     <= dq_fall_d;
            dq_oe_q       <= dq_oe_d;
            rwds_oe_q     <= rwds_oe_d;
            rwds_rise_q   <= rwds_rise_d;
            rwds_fall_q   <= rwds_fall_d;
            busy_q        <= busy_d;
        end
    end

    assign trans_ready_o = trans_ready_q;
    assign tx_ready_o    = tx_ready_q;
    assign cs_no         = cs_n_q;
    assign ck_en_o       = ck_en_q;
    assign dq_rise_o     = dq_rise_q;
    assign dq_fall_o     = dq_fall_q;
    assign dq_oe_o       = dq_oe_q;
    assign rwds_oe_o     = rwds_oe_q;
    assign rwds_rise_o   = rwds_rise_q;
    assign rwds_fall_o   = rwds_fall_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_hyperbus_tx_seq.sv
// Directed table-driven bench for hyperbus_tx_seq.
// Honours HYPERBUS_FIXED_LATENCY_EN when computing expected latency.
module tb_hyperbus_tx_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        trans_valid_i = 1'b0;
    logic        trans_ready_o;
    logic [47:0] trans_ca_i = '0;
    logic [8:0]  trans_burst_i = '0;
    logic [3:0]  cfg_latency_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [15:0] tx_data_i = '0;
    logic [1:0]  tx_strb_i = 2'b11;
    logic        rwds_i = 1'b0;
    logic        cs_no, ck_en_o, dq_oe_o, rwds_oe_o;
    logic        rwds_rise_o, rwds_fall_o, busy_o;
    logic [7:0]  dq_rise_o, dq_fall_o;

    int checks = 0;
    int errors = 0;

    hyperbus_tx_seq #(.CS_HOLD(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .trans_ca_i(trans_ca_i), .trans_burst_i(trans_burst_i),
        .cfg_latency_i(cfg_latency_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_data_i(tx_data_i), .tx_strb_i(tx_strb_i),
        .rwds_i(rwds_i), .cs_no(cs_no), .ck_en_o(ck_en_o),
        .dq_rise_o(dq_rise_o), .dq_fall_o(dq_fall_o),
        .dq_oe_o(dq_oe_o), .rwds_oe_o(rwds_oe_o),
        .rwds_rise_o(rwds_rise_o), .rwds_fall_o(rwds_fall_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [47:0] ca;
        logic [8:0]  burst;
        logic [3:0]  lat;
        logic        rwds;
        int          stall;
        logic [1:0]  strb;
        int          exp_lat;
        int          exp_cs;
    } vec_t;

`ifdef HYPERBUS_FIXED_LATENCY_EN
    localparam int FX = 1;
`else
    localparam int FX = 0;
`endif

    vec_t vecs[7];

    // {cs_no,ck_en,dq_oe,rwds_oe,busy,trans_ready,tx_ready,rwds r/f,dq r/f}
    localparam logic [24:0] RST_VEC = {7'b1000010, 2'b00, 16'h0000};

    function automatic logic [15:0] word(input int w);
        logic [15:0] t;
        t = 16'(w);
        return 16'hA55A ^ (t * 16'h0111);
    endfunction

    function automatic logic [24:0] out_vec();
        return {cs_no, ck_en_o, dq_oe_o, rwds_oe_o, busy_o, trans_ready_o,
                tx_ready_o, rwds_rise_o, rwds_fall_o, dq_rise_o, dq_fall_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int cyc, cs, ck, oe, roe, rdy, lc, oeidx, widx, stall_left, nw;
        logic tr_prev, rdy_prev, wr, is_reg, seen, done;
        logic [15:0] exp_w;
        wr     = !v.ca[47];
        is_reg = v.ca[46];
        nw     = int'(v.burst) + 1;
        @(negedge clk_i);
        trans_valid_i = 1'b1;
        trans_ca_i    = v.ca;
        trans_burst_i = v.burst;
        cfg_latency_i = v.lat;
        rwds_i        = v.rwds;
        tx_strb_i     = v.strb;
        tx_valid_i    = wr;
        tx_data_i     = word(0);
        tr_prev  = trans_ready_o;
        rdy_prev = tx_ready_o;
        widx = 0; stall_left = v.stall;
        cyc = 0; cs = 0; ck = 0; oe = 0; roe = 0; rdy = 0; lc = 0; oeidx = 0;
        seen = 1'b0; done = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
            if (trans_valid_i && tr_prev) trans_valid_i = 1'b0;
            tr_prev = trans_ready_o;
            if (tx_valid_i && rdy_prev) widx++;
            rdy_prev = tx_ready_o;
            if (wr && widx < nw) begin
                if (widx == 2 && stall_left > 0 && tx_ready_o) begin
                    tx_valid_i = 1'b0;
                    stall_left--;
                end else begin
                    tx_valid_i = 1'b1;
                    tx_data_i  = word(widx);
                end
            end else begin
                tx_valid_i = 1'b0;
            end
            if (tx_ready_o) rdy++;
            if (!cs_no) begin
                seen = 1'b1;
                cs++;
                if (ck_en_o) ck++;
                if (dq_oe_o) oe++;
                if (rwds_oe_o) roe++;
                if (ck_en_o && !dq_oe_o) lc++;
                if (ck_en_o && dq_oe_o) begin
                    if (oeidx < 3) begin
                        exp_w = v.ca[47-16*oeidx -: 16];
                        chk({nm, " ca_word"}, {48'h0, dq_rise_o, dq_fall_o},
                            {48'h0, exp_w});
                    end else begin
                        chk({nm, " data"},
                            {44'h0, rwds_oe_o, rwds_rise_o, rwds_fall_o,
                             dq_rise_o, dq_fall_o},
                            {44'h0, !is_reg, ~v.strb, word(oeidx - 3)});
                    end
                    oeidx++;
                end
            end else if (seen) begin
                done = 1'b1;
            end
        end
        chk({nm, " timeout"}, 64'(done), 64'd1);
        trans_valid_i = 1'b0;
        tx_valid_i    = 1'b0;
        rwds_i        = 1'b0;
        chk({nm, " cs_len"}, 64'(cs), 64'(v.exp_cs));
        chk({nm, " ck_cycles"}, 64'(ck), 64'(3 + v.exp_lat + nw));
        chk({nm, " lat_cycles"}, 64'(lc),
            64'(v.exp_lat + (wr ? 0 : nw)));
        chk({nm, " oe_cycles"}, 64'(oe),
            64'(wr ? 3 + nw + v.stall : 3));
        chk({nm, " rwds_oe_cycles"}, 64'(roe),
            64'((wr && !is_reg) ? nw + v.stall : 0));
        chk({nm, " rdy_cycles"}, 64'(rdy), 64'(wr ? nw + v.stall : 0));
        chk({nm, " words"}, 64'(oeidx - 3), 64'(wr ? nw : 0));
    endtask

    initial begin
        int cyc, falls, gap, oec;
        logic prev_cs;
        vecs[0] = '{48'h0000_0001_0000, 9'd3, 4'd6, 1'b0, 0, 2'b11,
                    FX ? 12 : 6, FX ? 27 : 21};
        vecs[0].exp_cs = FX ? 21 : 15;
        vecs[1] = '{48'h0000_0001_0000, 9'd3, 4'd6, 1'b1, 0, 2'b11,
                    12, 21};
        vecs[2] = '{48'h8000_0000_1234, 9'd0, 4'd4, 1'b0, 0, 2'b11,
                    FX ? 8 : 4, FX ? 14 : 10};
        vecs[3] = '{48'h0000_00AB_0040, 9'd5, 4'd3, 1'b1, 2, 2'b01,
                    6, 19};
        vecs[4] = '{48'h4000_0000_0001, 9'd0, 4'd6, 1'b0, 0, 2'b10,
                    0, 6};
        vecs[5] = '{48'hC000_0000_0002, 9'd511, 4'd2, 1'b0, 0, 2'b11,
                    FX ? 4 : 2, FX ? 521 : 519};
        vecs[6] = '{48'h0000_0000_0100, 9'd1, 4'd0, 1'b1, 0, 2'b11,
                    0, 7};

        repeat (3) @(negedge clk_i);
        chk("reset_state", 64'(out_vec()), 64'(RST_VEC));
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", 64'(out_vec()), 64'(RST_VEC));

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // reset asserted in the middle of a write burst
        @(negedge clk_i);
        trans_valid_i = 1'b1;
        trans_ca_i    = 48'h0000_0000_0200;
        trans_burst_i = 9'd7;
        cfg_latency_i = 4'd2;
        tx_strb_i     = 2'b11;
        tx_valid_i    = 1'b1;
        tx_data_i     = 16'h1234;
        oec = 0; cyc = 0;
        while (oec < 5 && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            trans_valid_i = 1'b0;
            if (!cs_no && ck_en_o && dq_oe_o) oec++;
        end
        chk("mid_reset_reached_data", 64'(oec), 64'd5);
        #2 rst_ni = 1'b0;
        #1 chk("mid_reset_outputs", 64'(out_vec()), 64'(RST_VEC));
        tx_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_reset_held", 64'(out_vec()), 64'(RST_VEC));
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_txn(vecs[0], "after_reset");

        // trans_valid held high: second request waits one idle cycle
        @(negedge clk_i);
        trans_valid_i = 1'b1;
        trans_ca_i    = 48'h4000_0000_0010;
        trans_burst_i = 9'd0;
        cfg_latency_i = 4'd6;
        tx_valid_i    = 1'b1;
        tx_data_i     = 16'hBEEF;
        prev_cs = cs_no;
        falls = 0; gap = 0; cyc = 0;
        while (falls < 2 && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            if (prev_cs && !cs_no) falls++;
            if (falls == 1 && cs_no) gap++;
            prev_cs = cs_no;
        end
        trans_valid_i = 1'b0;
        chk("b2b_two_txns", 64'(falls), 64'd2);
        chk("b2b_idle_gap", 64'(gap), 64'd1);
        cyc = 0;
        while (busy_o && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
        end
        tx_valid_i = 1'b0;
        chk("b2b_back_idle", 64'(busy_o), 64'd0);
        chk("b2b_cs_high", 64'(cs_no), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
